// File: rtl/clkgen_pkg.sv
// Shared definitions for the divided-clock bank: config opcodes, default
// field width and the per-channel configuration record.
package clkgen_pkg;

    localparam logic OP_WRITE  = 1'b0;
    localparam logic OP_COMMIT = 1'b1;

    localparam int CNT_W_DEF = 8;

    // Channel configuration at the default field width.
    typedef struct packed {
        logic                 en;
        logic [CNT_W_DEF-1:0] half;
        logic [CNT_W_DEF-1:0] phase;
    } ch_cfg_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divided-clock channel: half-period counter, registered 50 % clock,
// rising-edge tick and a sticky "has ticked" flag used for lock detection.
// The en/half/phase inputs are the channel's next-active configuration, so on
// the load strobe the freshly committed phase seeds the counter in that edge.
module clk_div_channel
    import clkgen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] half,
    input  logic [CNT_W-1:0] phase,
    output logic             div_clk,
    output logic             tick,
    output logic             seen_tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             seen_q, seen_d;

    // Counter advance, wrap-and-toggle at H-1, restart on load, hold at zero when disabled.
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        tick_d = 1'b0;
        seen_d = seen_q | tick_q;
        if (load) begin
            cnt_d  = phase;
            div_d  = 1'b0;
            seen_d = 1'b0;
        end else if (!en) begin
            cnt_d = '0;
            div_d = 1'b0;
        end else if (cnt_q == half - CNT_W'(1)) begin
            cnt_d  = '0;
            div_d  = ~div_q;
            tick_d = ~div_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Channel state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            div_q  <= 1'b0;
            tick_q <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            seen_q <= seen_d;
        end
    end

    assign div_clk   = div_q;
    assign tick      = tick_q;
    assign seen_tick = seen_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent clock dividers. Settings are staged per channel
// in shadow registers via WRITE beats and copied to every channel on the same
// edge by a COMMIT, keeping the derived clocks phase-aligned.
module clock_divider_bank
    import clkgen_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEFAULT_HALF = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_op,
    input  logic [3:0]        cfg_ch,
    input  logic              cfg_en,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] tick,
    output logic              locked
);

    typedef struct packed {
        logic             en;
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] phase;
    } cfg_t;

    localparam cfg_t CFG_RESET = {1'b1, CNT_W'(DEFAULT_HALF), {CNT_W{1'b0}}};

    cfg_t shadow_q [NUM_CH];
    cfg_t shadow_d [NUM_CH];
    cfg_t active_q [NUM_CH];
    cfg_t active_d [NUM_CH];

    logic commit_pending_q, commit_pending_d;
    logic cfg_ready_q, cfg_ready_d;
    logic cfg_err_q, cfg_err_d;
    logic locked_q, locked_d;

    logic accept;
    logic apply;
    logic wr_bad;

    logic [NUM_CH-1:0] ch_div;
    logic [NUM_CH-1:0] ch_tick;
    logic [NUM_CH-1:0] ch_seen;
    logic [NUM_CH-1:0] en_vec;

    assign accept = cfg_valid & cfg_ready_q;
    assign apply  = commit_pending_q;
    assign wr_bad = (cfg_half == '0) || (cfg_phase >= cfg_half) || (int'(cfg_ch) >= NUM_CH);

    // Config port: stage WRITEs into shadows, flag bad WRITEs, arm and apply COMMITs.
    always_comb begin
        shadow_d         = shadow_q;
        active_d         = active_q;
        commit_pending_d = commit_pending_q;
        cfg_err_d        = 1'b0;
        if (apply) begin
            active_d         = shadow_q;
            commit_pending_d = 1'b0;
        end
        if (accept) begin
            if (cfg_op == OP_COMMIT) begin
                commit_pending_d = 1'b1;
            end else if (wr_bad) begin
                cfg_err_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (cfg_ch == 4'(i)) begin
                        shadow_d[i] = {cfg_en, cfg_half, cfg_phase};
                    end
                end
            end
        end
        cfg_ready_d = ~commit_pending_d;
    end

    // Lock: every enabled channel has ticked (a tick this cycle counts) since reset/commit.
    always_comb begin
        en_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            en_vec[i] = active_q[i].en;
        end
        locked_d = apply ? 1'b0 : &(ch_seen | ch_tick | ~en_vec);
    end

    // Config, active settings and status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= CFG_RESET;
                active_q[i] <= CFG_RESET;
            end
            commit_pending_q <= 1'b0;
            cfg_ready_q      <= 1'b1;
            cfg_err_q        <= 1'b0;
            locked_q         <= 1'b0;
        end else begin
            shadow_q         <= shadow_d;
            active_q         <= active_d;
            commit_pending_q <= commit_pending_d;
            cfg_ready_q      <= cfg_ready_d;
            cfg_err_q        <= cfg_err_d;
            locked_q         <= locked_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .load      (apply),
            .en        (active_d[g].en),
            .half      (active_d[g].half),
            .phase     (active_d[g].phase),
            .div_clk   (ch_div[g]),
            .tick      (ch_tick[g]),
            .seen_tick (ch_seen[g])
        );
    end

    assign div_clk   = ch_div;
    assign tick      = ch_tick;
    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign locked    = locked_q;

endmodule
